onchip_mem_loader: RTL and testbench

Byte-stream-to-memory loader that feeds the 1024×32 single-port on-chip memory slave. It accepts an 8-bit valid/ready stream, packs bytes little-endian into 32-bit words, and issues single-cycle write transfers with matching byteenable to a programmed base word address. It sits directly upstream of the on-chip memory and is used to load program/data images at run time.

---
 rtl/onchip_mem_loader.sv | 178 +++++++++++++++++
 tb/tb_onchip_mem_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_loader.sv
// Byte stream to 1024x32 on-chip memory loader, little-endian word packing.
// Optional readback verify when ONCHIP_MEM_LOADER_VERIFY_EN is defined.
module onchip_mem_loader #(
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 13
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  num_bytes,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic              mem_clken,
   input  logic [31:0]       mem_readdata,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_written
);

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      WRITE,
`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
      VRD,
      VCMP,
`endif
      FINISH
   } state_t;

   state_t state, next;

   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [31:0]       word_q;
   logic [3:0]        mask_q;
   logic [ADDR_W:0]   wcnt_q;
   logic [1:0]        lane;
   logic              last;
   logic              more;

   function automatic logic [31:0] m32(input logic [3:0] b);
      return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
   endfunction

   assign lane = cnt_q[1:0];
   assign last = (cnt_q + LEN_W'(1)) == len_q;
   assign more = cnt_q != len_q;

   assign mem_address   = addr_q;
   assign mem_clken     = 1'b1;
   assign words_written = wcnt_q;

`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
   logic [3:0] be_q;
   logic       err_q;
   logic       mismatch;

   assign mismatch = (mem_readdata & m32(be_q)) != (word_q & m32(be_q));
   assign error    = err_q;
`else
   logic unused_rd;

   assign unused_rd = ^mem_readdata;
   assign error     = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next;
   end

   always_comb begin
      next           = state;
      in_ready       = 1'b0;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      mem_byteenable = 4'h0;
      mem_writedata  = 32'h0;
      busy           = 1'b0;
      done           = 1'b0;
      case (state)
         IDLE: begin
            if (start) next = (num_bytes != '0) ? COLLECT : FINISH;
         end
         COLLECT: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid && (lane == 2'd3 || last)) next = WRITE;
         end
         WRITE: begin
            busy           = 1'b1;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_byteenable = mask_q;
            mem_writedata  = word_q & m32(mask_q);
`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
            next = VRD;
`else
            next = more ? COLLECT : FINISH;
`endif
         end
`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
         VRD: begin
            busy           = 1'b1;
            mem_chipselect = 1'b1;
            mem_byteenable = be_q;
            next           = VCMP;
         end
         VCMP: begin
            busy = 1'b1;
            next = more ? COLLECT : FINISH;
         end
`endif
         FINISH: begin
            done = 1'b1;
            next = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q <= '0;
         len_q  <= '0;
         cnt_q  <= '0;
         word_q <= '0;
         mask_q <= '0;
         wcnt_q <= '0;
`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
         be_q   <= '0;
         err_q  <= 1'b0;
`endif
      end else if (state == IDLE) begin
         if (start && num_bytes != '0) begin
            addr_q <= base_addr;
            len_q  <= num_bytes;
            cnt_q  <= '0;
            mask_q <= '0;
            wcnt_q <= '0;
`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
            err_q  <= 1'b0;
`endif
         end
      end else if (state == COLLECT) begin
         if (in_valid) begin
            word_q[{lane, 3'b000} +: 8] <= in_data;
            mask_q[lane]                <= 1'b1;
            cnt_q                       <= cnt_q + LEN_W'(1);
         end
      end else if (state == WRITE) begin
         wcnt_q <= wcnt_q + (ADDR_W+1)'(1);
         mask_q <= '0;
`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
         be_q   <= mask_q;
`else
         addr_q <= addr_q + ADDR_W'(1);
`endif
      end
`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
      else if (state == VCMP) begin
         if (mismatch) err_q <= 1'b1;
         addr_q <= addr_q + ADDR_W'(1);
      end
`endif
   end

endmodule

// File: tb/tb_onchip_mem_loader.sv
// Randomized self-checking bench for onchip_mem_loader with a memory model
// and an expected-write scoreboard derived from the byte stream.
module tb_onchip_mem_loader;

   logic        clk;
   logic        reset;
   logic        start;
   logic [9:0]  base_addr;
   logic [12:0] num_bytes;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [9:0]  mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic        mem_clken;
   logic [31:0] mem_readdata;
   logic        busy;
   logic        done;
   logic        error;
   logic [10:0] words_written;

   onchip_mem_loader #(.ADDR_W(10), .LEN_W(13)) dut (
      .clk(clk), .reset(reset), .start(start),
      .base_addr(base_addr), .num_bytes(num_bytes),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata), .busy(busy), .done(done),
      .error(error), .words_written(words_written)
   );

   typedef struct packed {
      logic [9:0]  a;
      logic [31:0] d;
      logic [3:0]  be;
   } wr_t;

   int tests = 0;
   int fails = 0;
   int nwr   = 0;
   wr_t exp_q[$];
   logic [7:0] bq[$];
   logic [31:0] tbmem  [1024];
   logic [31:0] shadow [1024];
   logic [9:0]  rd_a;
   logic        corrupt;
   logic [9:0]  last_a;
   logic [31:0] last_d;
   logic [3:0]  last_be;

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // memory slave: registered address, unregistered read data
   always @(posedge clk) begin
      if (mem_chipselect && mem_write)
         for (int i = 0; i < 4; i++)
            if (mem_byteenable[i])
               tbmem[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
      if (mem_chipselect && !mem_write) rd_a <= mem_address;
   end
   assign mem_readdata = tbmem[rd_a] ^ (corrupt ? 32'h0000_FF00 : 32'h0);

   always @(negedge clk) begin
      if (!reset) begin
         chk("clken", mem_clken, 1);
         if (mem_write) begin
            nwr++;
            last_a  = mem_address;
            last_d  = mem_writedata;
            last_be = mem_byteenable;
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               chk("wr_addr", mem_address, e.a);
               chk("wr_data", mem_writedata, e.d);
               chk("wr_be", mem_byteenable, e.be);
               chk("wr_cs", mem_chipselect, 1);
               chk("wr_ready", in_ready, 0);
            end
         end
      end
   end

   task automatic check_reset_outs();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_cs", mem_chipselect, 0);
      chk("rst_write", mem_write, 0);
      chk("rst_be", mem_byteenable, 0);
      chk("rst_wdata", mem_writedata, 0);
      chk("rst_addr", mem_address, 0);
      chk("rst_words", words_written, 0);
      chk("rst_clken", mem_clken, 1);
   endtask

   // model: bytes pack 4 per word, little-endian, consecutive addresses mod 1024
   task automatic run_load(input logic [9:0] base, input int n, input int gap,
                           input bit extra, input bit exp_err,
                           output int lat);
      int idx, cyc, nw, bad;
      bit got, acc;
      nw = (n + 3) / 4;
      for (int w = 0; w < nw; w++) begin
         wr_t e;
         e.a  = base + 10'(w);
         e.d  = '0;
         e.be = '0;
         for (int k = 0; k < 4; k++)
            if (w*4 + k < n) begin
               e.d[8*k +: 8] = bq[w*4 + k];
               e.be[k] = 1'b1;
               shadow[e.a][8*k +: 8] = bq[w*4 + k];
            end
         exp_q.push_back(e);
      end
      start = 1; base_addr = base; num_bytes = 13'(n);
      @(posedge clk); #1 start = 0;
      idx = 0; cyc = 0; got = 0; lat = -1;
      while (!got && cyc < n*30 + 50) begin
         in_valid = (idx < n) && ($urandom_range(99) >= gap);
         in_data = in_valid ? bq[idx] : 8'($urandom);
         if (extra && cyc == 3) begin
            start = 1; num_bytes = 13'd5; base_addr = base + 10'd100;
         end
         @(negedge clk);
         if (cyc == 0) chk("busy_after_start", busy, n > 0);
         acc = in_valid && in_ready;
         if (done) begin
            got = 1; lat = cyc;
            chk("done_busy", busy, 0);
            if (n > 0) chk("words_written", words_written, nw);
            chk("error_at_done", error, exp_err);
         end
         @(posedge clk); #1;
         start = 0;
         if (acc) idx++;
         cyc++;
      end
      in_valid = 0;
      if (!got) chk("done_timeout", 0, 1);
      chk("exp_drained", exp_q.size(), 0);
      exp_q.delete();
      bad = 0;
      for (int a = 0; a < 1024; a++) if (tbmem[a] !== shadow[a]) bad++;
      chk("mem_image", bad, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
   endtask

   initial begin
      int lat, w0, n;
      for (int a = 0; a < 1024; a++) begin
         tbmem[a] = 0; shadow[a] = 0;
      end
      rd_a = 0; corrupt = 0;
      reset = 1; start = 0; base_addr = 0; num_bytes = 0;
      in_data = 0; in_valid = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outs();
      @(posedge clk); #1 reset = 0;

      // 8 bytes at 0x010, no gaps
      bq.delete();
      for (int i = 1; i <= 8; i++) bq.push_back(8'(i * 8'h11));
      run_load(10'h010, 8, 0, 0, 0, lat);
      chk("t1_word0", tbmem[10'h010], 32'h44332211);
      chk("t1_word1", tbmem[10'h011], 32'h88776655);
`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
      chk("t1_latency", lat, 14);
`else
      chk("t1_latency", lat, 10);
`endif

      // 6 bytes wrapping from 0x3FF to 0x000
      bq.delete();
      for (int i = 1; i <= 6; i++) bq.push_back(8'(i * 8'h11));
      run_load(10'h3FF, 6, 0, 0, 0, lat);
      chk("t2_word_3ff", tbmem[10'h3FF], 32'h44332211);
      chk("t2_last_addr", last_a, 10'h000);
      chk("t2_last_be", last_be, 4'h3);
      chk("t2_last_data", last_d, 32'h0000_6655);

      // zero-length load
      bq.delete();
      w0 = nwr;
      run_load(10'h055, 0, 0, 0, 0, lat);
      chk("t3_zero_latency", lat, 0);
      chk("t3_zero_nowrite", nwr, w0);

      // randomized loads with gaps and an ignored second start
      for (int t = 0; t < 8; t++) begin
         n = $urandom_range(1, 40);
         bq.delete();
         for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
         run_load(10'($urandom), n, 30, n >= 12, 0, lat);
      end

      // reset after two bytes of a word
      w0 = nwr;
      start = 1; base_addr = 10'h200; num_bytes = 13'd8;
      @(posedge clk); #1 start = 0;
      in_valid = 1; in_data = 8'hA1;
      @(posedge clk); #1 in_data = 8'hA2;
      @(posedge clk); #1 reset = 1; in_valid = 0;
      @(negedge clk);
      check_reset_outs();
      @(posedge clk); #1 reset = 0;
      repeat (4) @(posedge clk);
      #1 chk("t5_no_write_after_reset", nwr, w0);
      bq.delete();
      for (int i = 0; i < 7; i++) bq.push_back(8'($urandom));
      run_load(10'h200, 7, 20, 0, 0, lat);

`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
      // corrupted readback lane 1 sets a sticky error
      corrupt = 1;
      bq.delete();
      for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
      run_load(10'h100, 4, 0, 0, 1, lat);
      corrupt = 0;
      repeat (3) @(negedge clk);
      chk("t6_error_sticky", error, 1);
      bq.delete();
      for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
      run_load(10'h101, 4, 0, 0, 0, lat);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
